// File: rtl/fwd_sel_unit.sv
// Forwarding-select and load-use stall controller at the ID/EX boundary.
// Optional statistics counters are built only when FWD_STATS_EN is defined.
module fwd_sel_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [2:0]        sel_a,
    output logic [2:0]        sel_b,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  fwd_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } ent_t;

    // Entries 0..2 are EX, MEM, WB. Once a producer leaves WB, the select it
    // earned is already registered, so the post-WB stage needs no tag.
    localparam int NSH = 3;

    ent_t           sh_q [NSH];
    ent_t           sh_d [NSH];
    logic [NSH-1:0] hit_a;
    logic [NSH-1:0] hit_b;
    logic [2:0]     pri_a;
    logic [2:0]     pri_b;
    logic [2:0]     sel_a_q, sel_a_d;
    logic [2:0]     sel_b_q, sel_b_d;
    logic           kill;

    generate
        for (genvar gi = 0; gi < NSH; gi++) begin : g_match
            assign hit_a[gi] = sh_q[gi].valid && sh_q[gi].reg_write && id_use_rs
                               && (id_rs != '0) && (sh_q[gi].rd == id_rs);
            assign hit_b[gi] = sh_q[gi].valid && sh_q[gi].reg_write && id_use_rt
                               && (id_rt != '0) && (sh_q[gi].rd == id_rt);
        end
    endgenerate

    // Lowest set hit bit is the youngest producer; its one-hot position is the code.
    assign pri_a = hit_a & (~hit_a + 3'd1);
    assign pri_b = hit_b & (~hit_b + 3'd1);

    assign stall = id_valid && sh_q[0].mem_read && (hit_a[0] || hit_b[0]);
    assign kill  = flush || stall || !id_valid;

    always_comb begin
        for (int i = 0; i < NSH; i++) begin
            sh_d[i] = '0;
        end
        if (!kill) begin
            sh_d[0].valid     = 1'b1;
            sh_d[0].rd        = id_rd;
            sh_d[0].reg_write = id_reg_write;
            sh_d[0].mem_read  = id_mem_read;
        end
        for (int i = 1; i < NSH; i++) begin
            sh_d[i] = sh_q[i-1];
        end
        sel_a_d = kill ? 3'b000 : pri_a;
        sel_b_d = kill ? 3'b000 : pri_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSH; i++) begin
                sh_q[i] <= '0;
            end
            sel_a_q <= 3'b000;
            sel_b_q <= 3'b000;
        end else begin
            for (int i = 0; i < NSH; i++) begin
                sh_q[i] <= sh_d[i];
            end
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign sel_a = sel_a_q;
    assign sel_b = sel_b_q;

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
    logic [CNT_W:0]   stall_sum;
    logic [CNT_W:0]   fwd_sum;
    logic [1:0]       fwd_ops;

    // One extra sum bit detects wrap; a carry means saturate at all-ones.
    always_comb begin
        fwd_ops     = {1'b0, |sel_a_d} + {1'b0, |sel_b_d};
        stall_sum   = {1'b0, stall_cnt_q} + {{CNT_W{1'b0}}, stall};
        fwd_sum     = {1'b0, fwd_cnt_q} + {{(CNT_W-1){1'b0}}, fwd_ops};
        stall_cnt_d = stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
        fwd_cnt_d   = fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Self-checking bench for fwd_sel_unit: directed scenarios plus randomized
// traffic against a history-of-issued-instructions reference model.
module tb_fwd_sel_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic        id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  sel_a, sel_b, sel_a_s, sel_b_s;
    logic        stall, stall_s;
    logic [31:0] stall_cnt, fwd_cnt;
    logic [3:0]  stall_cnt_s, fwd_cnt_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_sel_unit #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .sel_a(sel_a), .sel_b(sel_b), .stall(stall),
        .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    fwd_sel_unit #(.REG_AW(5), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .sel_a(sel_a_s), .sel_b(sel_b_s), .stall(stall_s),
        .stall_cnt(stall_cnt_s), .fwd_cnt(fwd_cnt_s)
    );

    // Reference model: the last three instructions issued to EX, youngest first.
    bit     h_v [3];
    int     h_rd [3];
    bit     h_rw [3];
    bit     h_mr [3];
    bit     cur_v, cur_rw, cur_mr;
    int     cur_rd;
    bit     exp_stall;
    logic [2:0] exp_sel_a = 3'b000, exp_sel_b = 3'b000;
    logic [2:0] nxt_sel_a, nxt_sel_b;
    longint m_stall_c = 0, m_fwd_c = 0;

    function automatic logic [2:0] m_sel(input int s, input bit use_s);
        for (int i = 0; i < 3; i++) begin
            if (h_v[i] && h_rw[i] && h_rd[i] == s && s != 0 && use_s)
                return 3'b001 << i;
        end
        return 3'b000;
    endfunction

    function automatic longint exp_cnt(input longint c, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
`ifdef FWD_STATS_EN
        return (c > mx) ? mx : c;
`else
        return 0;
`endif
    endfunction

    task automatic issue(input bit v, input int rs, input int rt, input bit urs,
                         input bit urt, input int rd, input bit rw, input bit mr,
                         input bit fl);
        id_valid = v; id_rs = rs[4:0]; id_rt = rt[4:0];
        id_use_rs = urs; id_use_rt = urt; id_rd = rd[4:0];
        id_reg_write = rw; id_mem_read = mr; flush = fl;
        cur_v = v; cur_rd = rd; cur_rw = rw; cur_mr = mr;
        #1;
        exp_stall = v && h_v[0] && h_mr[0] && h_rw[0] &&
                    (m_sel(rs, urs) == 3'b001 || m_sel(rt, urt) == 3'b001);
        nxt_sel_a = (fl || exp_stall || !v) ? 3'b000 : m_sel(rs, urs);
        nxt_sel_b = (fl || exp_stall || !v) ? 3'b000 : m_sel(rt, urt);
    endtask

    task automatic edge_step();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) h_v[i] = 0;
            exp_sel_a = 3'b000; exp_sel_b = 3'b000;
            m_stall_c = 0; m_fwd_c = 0;
        end else begin
            for (int i = 2; i > 0; i--) begin
                h_v[i] = h_v[i-1]; h_rd[i] = h_rd[i-1];
                h_rw[i] = h_rw[i-1]; h_mr[i] = h_mr[i-1];
            end
            h_v[0] = cur_v && !exp_stall && !flush;
            h_rd[0] = cur_rd; h_rw[0] = cur_rw; h_mr[0] = cur_mr;
            if (exp_stall) m_stall_c++;
            m_fwd_c += (nxt_sel_a != 0) + (nxt_sel_b != 0);
            exp_sel_a = nxt_sel_a; exp_sel_b = nxt_sel_b;
        end
        #1;
    endtask

    task automatic nop_cycles(input int n);
        repeat (n) begin
            issue(1, 0, 0, 0, 0, 0, 0, 0, 0);
            edge_step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        issue(1, 0, 0, 0, 0, 0, 0, 0, 0);
        edge_step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (sel_a !== 3'b000 || sel_b !== 3'b000 || stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got sel_a=%b sel_b=%b stall=%b, want 000/000/0", sel_a, sel_b, stall);
        end
        total++;
        if (stall_cnt !== 32'd0 || fwd_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_counters: got stall_cnt=%0d fwd_cnt=%0d, want 0/0", stall_cnt, fwd_cnt);
        end
        $display("reset: sel_a=%b sel_b=%b stall=%b", sel_a, sel_b, stall);
    endtask

    task automatic test_alu_chain();
        nop_cycles(3);
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0);
        edge_step();
        issue(1, 3, 8, 1, 1, 10, 1, 0, 0);
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL alu_chain_stall: got %b, want 0", stall);
        end
        edge_step();
        total++;
        if (sel_a !== 3'b001 || sel_b !== 3'b000) begin
            bad++;
            $display("FAIL alu_chain_sel: got sel_a=%b sel_b=%b, want 001/000", sel_a, sel_b);
        end
        $display("alu_chain: sel_a=%b sel_b=%b", sel_a, sel_b);
    endtask

    task automatic test_distance();
        logic [2:0] want [4];
        want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100; want[3] = 3'b000;
        for (int k = 0; k < 4; k++) begin
            nop_cycles(3);
            issue(1, 0, 0, 0, 0, 5, 1, 0, 0);
            edge_step();
            for (int j = 0; j < k; j++) begin
                issue(1, 0, 0, 0, 0, 11, 1, 0, 0);
                edge_step();
            end
            issue(1, 12, 5, 1, 1, 13, 1, 0, 0);
            edge_step();
            total++;
            if (sel_b !== want[k] || sel_a !== 3'b000) begin
                bad++;
                $display("FAIL distance_%0d: got sel_a=%b sel_b=%b, want 000/%b", k + 1, sel_a, sel_b, want[k]);
            end
            $display("distance %0d: sel_b=%b", k + 1, sel_b);
        end
    endtask

    task automatic test_load_use();
        longint want_st, want_fw;
        do_reset();
        issue(1, 0, 0, 0, 0, 7, 1, 1, 0);
        edge_step();
        issue(1, 7, 0, 1, 0, 8, 1, 0, 0);
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL load_use_stall: got %b, want 1", stall);
        end
        edge_step();
        total++;
        if (sel_a !== 3'b000) begin
            bad++;
            $display("FAIL load_use_bubble_sel: got %b, want 000", sel_a);
        end
        issue(1, 7, 0, 1, 0, 8, 1, 0, 0);
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL load_use_single_stall: got %b, want 0", stall);
        end
        edge_step();
        total++;
        if (sel_a !== 3'b010) begin
            bad++;
            $display("FAIL load_use_sel: got %b, want 010", sel_a);
        end
        want_st = exp_cnt(1, 32);
        want_fw = exp_cnt(1, 32);
        total++;
        if (longint'(stall_cnt) !== want_st || longint'(fwd_cnt) !== want_fw) begin
            bad++;
            $display("FAIL load_use_counters: got stall_cnt=%0d fwd_cnt=%0d, want %0d/%0d", stall_cnt, fwd_cnt, want_st, want_fw);
        end
        $display("load_use: sel_a=%b stall_cnt=%0d fwd_cnt=%0d", sel_a, stall_cnt, fwd_cnt);
    endtask

    task automatic test_r0_priority();
        nop_cycles(3);
        issue(1, 0, 0, 0, 0, 0, 1, 0, 0);
        edge_step();
        issue(1, 0, 0, 1, 1, 14, 0, 0, 0);
        edge_step();
        total++;
        if (sel_a !== 3'b000 || sel_b !== 3'b000) begin
            bad++;
            $display("FAIL r0_no_forward: got sel_a=%b sel_b=%b, want 000/000", sel_a, sel_b);
        end
        issue(1, 0, 0, 0, 0, 4, 1, 0, 0);
        edge_step();
        issue(1, 0, 0, 0, 0, 4, 1, 0, 0);
        edge_step();
        issue(1, 15, 4, 1, 1, 16, 1, 0, 0);
        edge_step();
        total++;
        if (sel_b !== 3'b001) begin
            bad++;
            $display("FAIL youngest_wins: got sel_b=%b, want 001", sel_b);
        end
        $display("r0_priority: sel_b=%b", sel_b);
    endtask

    task automatic test_flush();
        nop_cycles(3);
        issue(1, 0, 0, 0, 0, 9, 1, 1, 0);
        edge_step();
        issue(1, 9, 0, 1, 0, 12, 1, 1, 1);
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL flush_stall_visible: got %b, want 1", stall);
        end
        edge_step();
        total++;
        if (sel_a !== 3'b000 || sel_b !== 3'b000) begin
            bad++;
            $display("FAIL flush_sel: got sel_a=%b sel_b=%b, want 000/000", sel_a, sel_b);
        end
        issue(1, 12, 9, 1, 1, 17, 1, 0, 0);
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_killed_stall: got %b, want 0", stall);
        end
        edge_step();
        total++;
        if (sel_a !== 3'b000 || sel_b !== 3'b010) begin
            bad++;
            $display("FAIL flush_after: got sel_a=%b sel_b=%b, want 000/010", sel_a, sel_b);
        end
        $display("flush: sel_a=%b sel_b=%b", sel_a, sel_b);
    endtask

    task automatic test_reset_mid();
        nop_cycles(3);
        issue(1, 0, 0, 0, 0, 6, 1, 0, 0);
        edge_step();
        rst = 1'b1;
        issue(1, 6, 6, 1, 1, 6, 1, 0, 0);
        edge_step();
        rst = 1'b0;
        total++;
        if (sel_a !== 3'b000 || sel_b !== 3'b000 || stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got sel_a=%b sel_b=%b stall=%b, want 000/000/0", sel_a, sel_b, stall);
        end
        issue(1, 6, 6, 1, 1, 18, 1, 0, 0);
        edge_step();
        total++;
        if (sel_a !== 3'b000 || sel_b !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid_no_fwd: got sel_a=%b sel_b=%b, want 000/000", sel_a, sel_b);
        end
        $display("reset_mid: sel_a=%b sel_b=%b", sel_a, sel_b);
    endtask

    task automatic test_saturation();
        longint want_s;
        do_reset();
        issue(1, 0, 0, 0, 0, 1, 1, 0, 0);
        edge_step();
        repeat (10) begin
            issue(1, 1, 1, 1, 1, 1, 1, 0, 0);
            edge_step();
        end
        want_s = exp_cnt(20, 4);
        total++;
        if (longint'(fwd_cnt_s) !== want_s) begin
            bad++;
            $display("FAIL fwd_cnt_saturate: got %0d, want %0d", fwd_cnt_s, want_s);
        end
        want_s = exp_cnt(m_fwd_c, 32);
        total++;
        if (longint'(fwd_cnt) !== want_s) begin
            bad++;
            $display("FAIL fwd_cnt_wide: got %0d, want %0d", fwd_cnt, want_s);
        end
        $display("saturation: fwd_cnt_s=%0d fwd_cnt=%0d", fwd_cnt_s, fwd_cnt);
    endtask

    task automatic test_random();
        int errs_before;
        longint w_st, w_fw, w_st4, w_fw4;
        errs_before = bad;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            issue($urandom_range(0, 99) < 85, $urandom_range(0, 5), $urandom_range(0, 5),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
            total++;
            if (stall !== exp_stall || stall_s !== exp_stall) begin
                bad++;
                $display("FAIL rand_stall[%0d]: got %b/%b, want %b", n, stall, stall_s, exp_stall);
            end
            edge_step();
            total++;
            if (sel_a !== exp_sel_a || sel_b !== exp_sel_b || sel_a_s !== exp_sel_a || sel_b_s !== exp_sel_b) begin
                bad++;
                $display("FAIL rand_sel[%0d]: got sel_a=%b sel_b=%b, want %b/%b", n, sel_a, sel_b, exp_sel_a, exp_sel_b);
            end
            w_st = exp_cnt(m_stall_c, 32); w_fw = exp_cnt(m_fwd_c, 32);
            w_st4 = exp_cnt(m_stall_c, 4); w_fw4 = exp_cnt(m_fwd_c, 4);
            total++;
            if (longint'(stall_cnt) !== w_st || longint'(fwd_cnt) !== w_fw ||
                longint'(stall_cnt_s) !== w_st4 || longint'(fwd_cnt_s) !== w_fw4) begin
                bad++;
                $display("FAIL rand_counters[%0d]: got %0d/%0d/%0d/%0d, want %0d/%0d/%0d/%0d", n,
                         stall_cnt, fwd_cnt, stall_cnt_s, fwd_cnt_s, w_st, w_fw, w_st4, w_fw4);
            end
        end
        rst = 1'b0;
        $display("random: 600 cycles, new errors=%0d", bad - errs_before);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            h_v[i] = 0; h_rd[i] = 0; h_rw[i] = 0; h_mr[i] = 0;
        end
        test_reset();
        test_alu_chain();
        test_distance();
        test_load_use();
        test_r0_priority();
        test_flush();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_sel_unit.md
Name: fwd_sel_unit

Overview:
- Forwarding and load-use hazard controller in the ID/EX boundary of the 5-stage pipeline.
- Tracks destination registers of in-flight instructions in an internal shadow pipeline (EX, MEM, WB, WB+1).
- Drives the 3-bit one-hot select codes of the two EX-stage ALU-operand 4:1 muxes and the ID/PC stall signal.
- Select encoding: 000 = register-file value, 001 = EX/MEM result, 010 = MEM/WB result, 100 = post-WB holding register; other codes are illegal.

Parameters:
REG_AW, 5, register-address width (32 architectural registers; register 0 is hard-wired zero)
CNT_W, 32, width of the statistics counters (used only with FWD_STATS_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
id_valid  input  1  ID-stage instruction valid
id_rs  input  REG_AW  ID source register A
id_rt  input  REG_AW  ID source register B
id_use_rs  input  1  instruction reads rs
id_use_rt  input  1  instruction reads rt
id_rd  input  REG_AW  ID destination register
id_reg_write  input  1  instruction writes id_rd
id_mem_read  input  1  instruction is a load
flush  input  1  branch/jump flush; kill the instruction entering EX
sel_a  output  3  operand-A mux select, valid in the EX cycle
sel_b  output  3  operand-B mux select, valid in the EX cycle
stall  output  1  hold PC and IF/ID this cycle (combinational)
stall_cnt  output  CNT_W  stall-cycle count (FWD_STATS_EN only)
fwd_cnt  output  CNT_W  forwarded-operand count (FWD_STATS_EN only)

Behaviour:
- Single clock, synchronous active-high rst. On reset all shadow entries are invalid, sel_a = sel_b = 000, stall = 0, counters = 0.
- Each shadow entry holds {valid, rd, reg_write, mem_read}. Every cycle the entries advance EX→MEM→WB→WB1; WB1 is discarded on the next cycle.
- EX entry load:
  - From the ID inputs when id_valid=1, stall=0 and flush=0.
  - Otherwise a bubble (valid=0) is loaded.
- A shadow entry is a forwarding match for source s only when all hold: valid, reg_write, rd == s, s != 0, and the matching use_* flag is set.
- Select for each operand is computed in the ID cycle and registered, so it is presented during the instruction's EX cycle (1-cycle latency). Nearest-first priority:
  - current EX entry matches (will be in MEM) → 001
  - else current MEM entry → 010
  - else current WB entry → 100
  - else 000
- Load-use stall:
  - stall = id_valid & EX.valid & EX.mem_read & EX.reg_write & (rs or rt match per the rules above).
  - Exactly one stall cycle per hazard. On the next cycle the load sits in MEM and the ID recomputation yields 010.
- While stall=1: a bubble is inserted into EX, and the registered sel_a/sel_b become 000.
- flush=1: bubble into EX and sel_a/sel_b become 000 for the next cycle. flush takes precedence over stall; stall is still output as computed.
- Bubbles and flushed instructions never match.
- Simultaneous matches in several stages always resolve to the youngest producer.
- rst mid-operation clears every shadow entry in the same edge. No forwarding reaches across a reset.

Optional Feature:
- Macro FWD_STATS_EN.
- When defined:
  - stall_cnt increments on every cycle with stall=1.
  - fwd_cnt increments by the number of operands (0, 1 or 2) whose newly registered select is non-zero.
  - Both counters saturate at all-ones and clear on rst.
- When undefined: no counter logic is built; stall_cnt and fwd_cnt are tied to 0.

Test Plan:
- ALU chain: add r3 written, next instruction reads rs=r3 → in its EX cycle sel_a=001, sel_b=000, stall never asserted.
- Distance 2 and 3: producer r5, then one unrelated instruction, then consumer rt=r5 → sel_b=010. With two unrelated instructions between → sel_b=100. With three → 000.
- Load-use: lw r7 followed by consumer rs=r7 → stall=1 for exactly one cycle, bubble in EX, then the consumer's EX cycle has sel_a=010. With FWD_STATS_EN, stall_cnt=1 and fwd_cnt=1.
- Register 0 and priority:
  - producer writes r0, consumer reads r0 → sel=000.
  - Two producers of r4 at distance 1 and 2 → sel=001 (youngest wins).
- Flush/reset:
  - flush asserted with a consumer of the EX-stage r9 → the next cycle sel_a=000 and no stall results from the killed entry.
  - rst asserted mid-stream → all outputs 000/0 on the following cycle, and a later reader of a pre-reset rd gets 000.
- Saturation (FWD_STATS_EN, CNT_W=4): 20 forwarded operands → fwd_cnt holds at 15.
